// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the rotating-priority pick helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {ARB = 1'b0, BURST = 1'b1} arb_state_t;

   localparam int STAT_W  = 16;
   localparam int RR_MAXN = 8;

   // First set bit of valid scanning ptr, ptr+1, ... modulo n; returns ptr when none is set.
   function automatic logic [2:0] rr_pick(input logic [RR_MAXN-1:0] valid,
                                          input logic [2:0] ptr,
                                          input int n);
      int k;
      rr_pick = ptr;
      for (int i = RR_MAXN - 1; i >= 0; i--) begin
         if (i < n) begin
            k = (int'(ptr) + i) % n;
            if (valid[k[2:0]]) rr_pick = k[2:0];
         end
      end
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the arbiter; master is the arbiter's view.
interface fifo_wr_arbiter_if #(
   parameter int DSIZE = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) ();
   logic [NREQ-1:0]       s_valid;
   logic [NREQ*DSIZE-1:0] s_data;
   logic [NREQ-1:0]       s_ready;
   logic                  wfull;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic                  grant_vld;
   logic [IDW-1:0]        grant_id;

   modport master (input s_valid, s_data, wfull,
                   output s_ready, winc, wdata, grant_vld, grant_id);
   modport slave  (output s_valid, s_data, wfull,
                   input s_ready, winc, wdata, grant_vld, grant_id);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: valid vector + start pointer -> winning index and found flag.
module rr_pick_nreq
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [IDW-1:0]  idx_o,
   output logic            found_o
);
   logic [RR_MAXN-1:0] valid_ext;
   logic [2:0]         ptr_ext;
   logic [2:0]         pick;

   assign valid_ext = RR_MAXN'(valid_i);
   assign ptr_ext   = 3'(ptr_i);
   assign pick      = rr_pick(valid_ext, ptr_ext, NREQ);
   assign idx_o     = IDW'(pick);
   assign found_o   = |valid_i;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port; first s_ready one cycle after s_valid, stalls on wfull.
// FIFO_WR_ARB_STATS_EN adds per-requester accepted-word counts and a wfull stall counter.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DSIZE     = 8,
   parameter int NREQ      = 4,
   parameter int BURST_LEN = 4
) (
   input  logic               wclk,
   input  logic               wrst,
   fifo_wr_arbiter_if.master  bus
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0] stat_cnt,
   output logic [STAT_W-1:0]      stall_cnt
`endif
);
   localparam int IDW = $clog2(NREQ);
   localparam int BCW = $clog2(BURST_LEN) + 1;

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [IDW-1:0]   pick_idx;
   logic             pick_found;
   logic             g_valid;
   logic             last_beat;
   logic [NREQ-1:0]  s_ready;
   logic             winc;
   logic [DSIZE-1:0] wdata;
   logic             grant_vld;

   rr_pick_nreq #(.NREQ(NREQ)) u_pick (
      .valid_i (bus.s_valid),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   assign g_valid   = bus.s_valid[grant_id_q];
   assign last_beat = (beat_cnt_q == BCW'(BURST_LEN - 1));

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      s_ready    = '0;
      winc       = 1'b0;
      wdata      = '0;
      grant_vld  = 1'b0;
      case (state_q)
         ARB: begin
            if (pick_found && !bus.wfull) begin
               grant_id_d = pick_idx;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            grant_vld           = 1'b1;
            s_ready[grant_id_q] = ~bus.wfull;
            winc                = g_valid & ~bus.wfull;
            if (winc) begin
               wdata = bus.s_data[grant_id_q*DSIZE +: DSIZE];
               if (!last_beat) beat_cnt_d = beat_cnt_q + 1'b1;
            end
            // Full burst done, or the owner went idle while the FIFO had room.
            if ((winc && last_beat) || (!bus.wfull && !g_valid)) begin
               state_d  = ARB;
               rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
      // Reset masks outputs immediately so an in-flight word is never written.
      if (wrst) begin
         s_ready   = '0;
         winc      = 1'b0;
         wdata     = '0;
         grant_vld = 1'b0;
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q    <= ARB;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.winc      = winc;
   assign bus.wdata     = wdata;
   assign bus.grant_vld = grant_vld;
   assign bus.grant_id  = grant_id_q;

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NREQ];
   logic [STAT_W-1:0] stall_q;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (winc && grant_id_q == IDW'(i) && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 1'b1;
         end
         if (state_q == BURST && bus.wfull && stall_q != '1) stall_q <= stall_q + 1'b1;
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_stat
      assign stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
   end
   assign stall_cnt = stall_q;
`else
   // Core-only build: no statistics state.
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + randomized bench for fifo_wr_arbiter against a word-level behavioural model.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int DSIZE     = 8;
   localparam int NREQ      = 4;
   localparam int BURST_LEN = 4;

   logic wclk = 1'b0;
   logic wrst = 1'b1;
   always #5 wclk = ~wclk;

   fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus_if ();

`ifdef FIFO_WR_ARB_STATS_EN
   logic [NREQ*STAT_W-1:0] stat_cnt;
   logic [STAT_W-1:0]      stall_cnt;
`endif

   fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_LEN(BURST_LEN)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus_if)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stat_cnt  (stat_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   int n_pass = 0, n_checks = 0, n_fail = 0;
   logic [NREQ-1:0] sv = '1;
   bit wf = 1'b0;
   int seq [NREQ];
   bit m_busy = 0;
   int m_owner = 0, m_beats = 0, m_ptr = 0;
   int m_stat [NREQ];
   int m_stall = 0;
   int words_total = 0;
   int words_req [NREQ];
   bit auto_mode = 0;
   int on_pct = 50, keep_pct = 60, full_pct = 20;

   function automatic logic [DSIZE-1:0] word_of(int i);
      return DSIZE'(i * 16 + seq[i] % 16);
   endfunction

   function automatic int first_from(logic [NREQ-1:0] v, int p);
      for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      bus_if.s_valid = sv;
      for (int i = 0; i < NREQ; i++) bus_if.s_data[i*DSIZE +: DSIZE] = word_of(i);
      bus_if.wfull = wf;
   endtask

   task automatic clear_counts();
      words_total = 0;
      for (int i = 0; i < NREQ; i++) words_req[i] = 0;
   endtask

   // One clock: drive, compare at negedge, advance the model, then let the edge happen.
   task automatic step();
      logic [NREQ-1:0]  exp_rdy;
      logic [DSIZE-1:0] exp_wdata;
      bit xfer;
      int f, xo;
      apply();
      @(negedge wclk);
      exp_rdy = '0; exp_wdata = '0; xfer = 0; xo = -1;
      if (!wrst && m_busy) begin
         exp_rdy[m_owner] = !wf;
         xfer = sv[m_owner] && !wf;
         if (xfer) begin exp_wdata = word_of(m_owner); xo = m_owner; end
      end
      chk("grant_vld", 32'(bus_if.grant_vld), 32'(!wrst && m_busy));
      chk("s_ready", 32'(bus_if.s_ready), 32'(exp_rdy));
      chk("winc", 32'(bus_if.winc), 32'(xfer));
      chk("wdata", 32'(bus_if.wdata), 32'(exp_wdata));
      chk("winc_while_full", 32'(bus_if.winc & bus_if.wfull), 32'(0));
      if (!wrst) chk("grant_id", 32'(bus_if.grant_id), 32'(m_owner));
      if (bus_if.winc === 1'b1) begin
         words_total++;
         words_req[bus_if.grant_id]++;
      end
      if (wrst) begin
         m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
         for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
      end else if (!m_busy) begin
         f = first_from(sv, m_ptr);
         if (f >= 0 && !wf) begin m_busy = 1; m_owner = f; m_beats = 0; end
      end else begin
         if (wf) m_stall++;
         if (xfer) begin
            m_beats++;
            seq[m_owner]++;
            m_stat[m_owner]++;
            if (m_beats == BURST_LEN) begin m_busy = 0; m_ptr = (m_owner + 1) % NREQ; end
         end else if (!wf && !sv[m_owner]) begin
            m_busy = 0; m_ptr = (m_owner + 1) % NREQ;
         end
      end
      if (auto_mode) begin
         for (int i = 0; i < NREQ; i++) begin
            if (i == xo) sv[i] = int'($urandom_range(99)) < keep_pct;
            else if (!sv[i]) sv[i] = int'($urandom_range(99)) < on_pct;
         end
         wf = int'($urandom_range(99)) < full_pct;
      end
      @(posedge wclk);
      #1;
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_reset(logic [NREQ-1:0] v_after);
      wrst = 1'b1; sv = '0; wf = 1'b0;
      steps(2);
      wrst = 1'b0; sv = v_after;
      clear_counts();
   endtask

`ifdef FIFO_WR_ARB_STATS_EN
   task automatic chk_stats();
      for (int i = 0; i < NREQ; i++) chk("stat_cnt", 32'(stat_cnt[i*STAT_W +: STAT_W]), 32'(m_stat[i]));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
   endtask
`endif

   initial begin
      for (int i = 0; i < NREQ; i++) begin seq[i] = 0; m_stat[i] = 0; words_req[i] = 0; end

      // Reset held with every requester valid.
      wrst = 1'b1; sv = '1; wf = 1'b0;
      steps(3);
      wrst = 1'b0;
      clear_counts();
      step();
      chk("first_grant_vld", 32'(bus_if.grant_vld), 32'(1));
      chk("first_grant_id", 32'(bus_if.grant_id), 32'(0));

      // Fairness: 20 cycles from release give 4 words to each requester.
      steps(19);
      chk("rr_words_total", 32'(words_total), 32'(16));
      for (int i = 0; i < NREQ; i++) chk("rr_words_req", 32'(words_req[i]), 32'(4));

      // Early release by req2, then rotation restarts from index 3.
      pulse_reset(4'b0100);
      steps(3);
      sv = 4'b0000;
      step();
      chk("early_release_vld", 32'(bus_if.grant_vld), 32'(0));
      chk("early_release_words", 32'(words_req[2]), 32'(2));
      sv = 4'b0100;
      step();
      chk("regrant_req2", 32'(bus_if.grant_id), 32'(2));
      steps(4);
      sv = 4'b1010;
      step();
      chk("scan_from_3", 32'(bus_if.grant_id), 32'(3));
      chk("scan_from_3_vld", 32'(bus_if.grant_vld), 32'(1));

      // wfull stall for 5 cycles after the second beat.
      pulse_reset(4'b0001);
      steps(3);
      wf = 1'b1;
      steps(5);
      chk("stall_grant_vld", 32'(bus_if.grant_vld), 32'(1));
      chk("stall_grant_id", 32'(bus_if.grant_id), 32'(0));
      chk("stall_words_so_far", 32'(words_total), 32'(2));
      wf = 1'b0;
      steps(2);
      chk("stall_words_req0", 32'(words_req[0]), 32'(4));
      chk("stall_words_total", 32'(words_total), 32'(4));
      sv = 4'b0000;
      step();

      // Reset during the third beat of req1.
      pulse_reset(4'b1111);
      steps(8);
      wrst = 1'b1;
      step();
      wrst = 1'b0;
      chk("midrst_grant_vld", 32'(bus_if.grant_vld), 32'(0));
      chk("midrst_req1_words", 32'(words_req[1]), 32'(2));
      step();
      chk("midrst_regrant_id", 32'(bus_if.grant_id), 32'(0));

      // Three rotations with 7 stall cycles inside a burst.
      pulse_reset(4'b1111);
      steps(32);
      wf = 1'b1;
      steps(7);
      wf = 1'b0;
      steps(28);
      for (int i = 0; i < NREQ; i++) chk("rot3_words_req", 32'(words_req[i]), 32'(12));
`ifdef FIFO_WR_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) chk("rot3_stat_cnt", 32'(stat_cnt[i*STAT_W +: STAT_W]), 32'(12));
      chk("rot3_stall_cnt", 32'(stall_cnt), 32'(7));
`endif

      // Randomized traffic with random wfull, checked cycle by cycle against the model.
      pulse_reset(4'b0000);
      auto_mode = 1;
      steps(3000);
`ifdef FIFO_WR_ARB_STATS_EN
      chk_stats();
`endif
      auto_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
